count_step_monitor: RTL and testbench
=====================================

// Module: count_step_monitor
// PURPOSE
//  Downstream consumer of the parameterised up/down counter: samples its N-bit count
//  each valid cycle and classifies every step as hold, +1, -1 or illegal.
//  Tracks direction, pulses on wrap-around, keeps a saturating lap count and latches
//  a sticky fault on any illegal jump. Used as a self-check/monitor beside the counter.
// PARAMETERS
//  N        3  count width; must be >= 2 (for N=1, +1 and -1 are indistinguishable)
//  LAP_W    8  width of lap_cnt
//  IRQ_LAPS 4  lap count that fires irq (used only with COUNT_MON_IRQ_EN)
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  reset      in   1      asynchronous, active-high reset
//  clr        in   1      synchronous clear; drive together with the counter's own reset
//  cnt_vld    in   1      cnt_in is valid this cycle
//  cnt_in     in   N      count value from the counter
//  dir        out  1      0 = up/unknown, 1 = counting down
//  wrap_pulse out  1      one-cycle pulse per detected wrap
//  lap_cnt    out  LAP_W  number of wraps since reset/clr; saturates at all-ones
//  fault      out  1      sticky illegal-step flag
//  irq        out  1      present only when COUNT_MON_IRQ_EN is defined
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-high.
//    Asserting reset forces state=IDLE, prev=0, and all outputs to 0 immediately,
//    including mid-stream.
//  - Priority: reset > clr > cnt_vld.
//    clr forces the same values as reset, but synchronously. A sample arriving in the
//    same cycle as clr is discarded.
//  - State machine. States: IDLE (no previous sample), SYNC (previous sample held,
//    direction unknown), UP, DOWN, FAULT.
//  - IDLE: a valid sample is stored in prev and the state moves to SYNC.
//    No step classification is done on this sample.
//  - SYNC, UP and DOWN: for a valid sample s, compute d = (s - prev) mod 2^N:
//      d == 0          hold; state unchanged.
//      d == 1          up step; next state UP.
//                      Wrap if prev == 2^N-1 and s == 0.
//      d == 2^N-1      down step; next state DOWN.
//                      Wrap if prev == 0 and s == 2^N-1.
//      any other d     illegal; next state FAULT.
//    In every case except FAULT, prev <= s.
//  - FAULT: all samples are ignored. No wraps are detected and lap_cnt is frozen.
//    Only clr or reset leaves FAULT.
//  - Cycles with cnt_vld = 0 change nothing.
//    Gaps between valid samples are allowed and do not count as steps.
//  - Outputs are registered, with 1-cycle latency from the sample edge:
//      dir        = 1 only in DOWN
//      fault      = 1 only in FAULT
//      wrap_pulse = 1 in the cycle after the wrapping sample is accepted
//      lap_cnt    increments together with wrap_pulse; at all-ones it holds
//                 (wrap_pulse still fires)
//  - Direction reversal (UP to DOWN or back) is legal and does not set fault.
//  - Arithmetic: subtraction is done N bits wide with natural modulo.
//    No sign extension is used.
// CONFIGURATION
//  COUNT_MON_IRQ_EN defined:
//    - Port irq exists.
//    - irq is a one-cycle pulse, coincident with wrap_pulse, on the wrap that moves
//      lap_cnt from IRQ_LAPS-1 to IRQ_LAPS.
//    - It fires once per clr/reset epoch.
//    - irq resets to 0.
//  COUNT_MON_IRQ_EN undefined:
//    - No irq port and no irq logic.
//    - IRQ_LAPS is ignored.
//    - All other behaviour is identical.
// TESTING (N=3, LAP_W=8 unless noted)
//  1. Reset, then clr; send samples 0,1,...,7,0.
//     -> wrap_pulse exactly once, the cycle after the final 0.
//     -> lap_cnt=1, dir=0, fault=0.
//  2. After clr, send samples 2,1,0,7.
//     -> dir=1 after sample 1.
//     -> wrap_pulse the cycle after 7; lap_cnt=1; fault=0.
//  3. Send samples 3,5 (d=2).
//     -> fault=1 the next cycle.
//     -> Then send 6,7,0: no wrap_pulse, lap_cnt unchanged.
//     -> clr: fault=0, state IDLE.
//  4. Send 4, 4, 4, 5, 4 with cnt_vld gaps between samples.
//     -> No fault; dir goes 0 then 1; no wrap.
//  5. Send 7, then 0 in the same cycle as clr.
//     -> No wrap_pulse; lap_cnt=0; next sample is treated as the first.
//     -> LAP_W=2, 5 up-wraps: lap_cnt saturates at 3 while wrap_pulse still pulses.
//  6. COUNT_MON_IRQ_EN with IRQ_LAPS=2: send two up-wraps.
//     -> irq only with the 2nd wrap_pulse.
//     -> Assert reset asynchronously mid-count: all outputs drop to 0 before the next edge.

Source files
------------

// File: rtl/count_step_monitor_if.sv
// Bundle between an up/down counter and count_step_monitor.
// The irq signal exists only when COUNT_MON_IRQ_EN is defined.
interface count_step_monitor_if #(
  parameter int N     = 3,
  parameter int LAP_W = 8
);
  logic             clr;
  logic             cnt_vld;
  logic [N-1:0]     cnt_in;
  logic             dir;
  logic             wrap_pulse;
  logic [LAP_W-1:0] lap_cnt;
  logic             fault;
`ifdef COUNT_MON_IRQ_EN
  logic             irq;
`endif

  modport master (
    output clr, cnt_vld, cnt_in,
`ifdef COUNT_MON_IRQ_EN
    input  irq,
`endif
    input  dir, wrap_pulse, lap_cnt, fault
  );

  modport slave (
    input  clr, cnt_vld, cnt_in,
`ifdef COUNT_MON_IRQ_EN
    output irq,
`endif
    output dir, wrap_pulse, lap_cnt, fault
  );
endinterface

// File: rtl/count_step_monitor.sv
// Classifies each valid count sample as hold/+1/-1/illegal, tracks direction, wraps and laps.
// Optional lap-threshold interrupt is built when COUNT_MON_IRQ_EN is defined.
module count_step_monitor #(
  parameter int N     = 3,
  parameter int LAP_W = 8
`ifdef COUNT_MON_IRQ_EN
  , parameter int IRQ_LAPS = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  count_step_monitor_if.slave mon
);

  typedef enum logic [2:0] {IDLE, SYNC, UP, DOWN, FAULT} state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] STEP_UP = N'(1);
  localparam logic [N-1:0] STEP_DN = '1;

  state_t           state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic             wrap_q, wrap_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic [N-1:0]     step;
  logic             is_wrap;

  // Modulo-2^N difference; no sign extension on purpose.
  assign step = mon.cnt_in - prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      wrap_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wrap_q  <= wrap_d;
      lap_q   <= lap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wrap_d  = 1'b0;
    lap_d   = lap_q;
    is_wrap = 1'b0;
    if (mon.clr) begin
      state_d = IDLE;
      prev_d  = '0;
      lap_d   = '0;
    end else if (mon.cnt_vld) begin
      case (state_q)
        IDLE: begin
          prev_d  = mon.cnt_in;
          state_d = SYNC;
        end
        SYNC, UP, DOWN: begin
          if (step == STEP_UP) begin
            state_d = UP;
            prev_d  = mon.cnt_in;
            is_wrap = (prev_q == CNT_MAX) && (mon.cnt_in == '0);
          end else if (step == STEP_DN) begin
            state_d = DOWN;
            prev_d  = mon.cnt_in;
            is_wrap = (prev_q == '0) && (mon.cnt_in == CNT_MAX);
          end else if (step == '0) begin
            prev_d  = mon.cnt_in;
          end else begin
            // prev is left as-is: FAULT never looks at it again before clr/reset.
            state_d = FAULT;
          end
        end
        default: begin
        end
      endcase
    end
    if (is_wrap) begin
      wrap_d = 1'b1;
      if (lap_q != '1) lap_d = lap_q + LAP_W'(1);
    end
  end

  assign mon.dir        = (state_q == DOWN);
  assign mon.fault      = (state_q == FAULT);
  assign mon.wrap_pulse = wrap_q;
  assign mon.lap_cnt    = lap_q;

`ifdef COUNT_MON_IRQ_EN
  logic irq_q, irq_d;

  // Saturation means lap_cnt can cross the threshold at most once per epoch.
  always_comb begin
    irq_d = 1'b0;
    if (!mon.clr && is_wrap && (lap_q != '1) && (32'(lap_q) == 32'(IRQ_LAPS - 1)))
      irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign mon.irq = irq_q;
`endif

endmodule

// File: tb/tb_count_step_monitor.sv
// Randomized and directed bench for count_step_monitor (N=3) with LAP_W=8 and LAP_W=2 instances.
module tb_count_step_monitor;
  localparam int M        = 8;
  localparam int IRQ_LAPS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  count_step_monitor_if #(.N(3), .LAP_W(8)) if0 ();
  count_step_monitor_if #(.N(3), .LAP_W(2)) if1 ();

  count_step_monitor #(
    .N(3), .LAP_W(8)
`ifdef COUNT_MON_IRQ_EN
    , .IRQ_LAPS(IRQ_LAPS)
`endif
  ) u_dut0 (.clk(clk), .reset(reset), .mon(if0.slave));

  count_step_monitor #(
    .N(3), .LAP_W(2)
`ifdef COUNT_MON_IRQ_EN
    , .IRQ_LAPS(IRQ_LAPS)
`endif
  ) u_dut1 (.clk(clk), .reset(reset), .mon(if1.slave));

  logic [1:0]  irq_obs;
  logic [17:0] obs;
`ifdef COUNT_MON_IRQ_EN
  assign irq_obs = {if0.irq, if1.irq};
`else
  assign irq_obs = 2'b00;
`endif
  assign obs = {if0.dir, if0.fault, if0.wrap_pulse, if0.lap_cnt,
                if1.dir, if1.fault, if1.wrap_pulse, if1.lap_cnt, irq_obs};

  // Reference model: last sample, direction, fault and lap counts as plain integers.
  bit m_have, m_dir, m_flt, m_wr, m_irq0, m_irq1;
  int m_prev, m_lap0, m_lap1;

  function automatic void model_clear();
    m_have = 0; m_dir = 0; m_flt = 0; m_wr = 0; m_irq0 = 0; m_irq1 = 0;
    m_prev = 0; m_lap0 = 0; m_lap1 = 0;
  endfunction

  function automatic void model_step(input bit c, input bit v, input int s);
    int d;
    bit wrapped;
    wrapped = 0; m_wr = 0; m_irq0 = 0; m_irq1 = 0;
    if (c) model_clear();
    else if (v && !m_flt) begin
      if (!m_have) begin
        m_have = 1; m_prev = s;
      end else begin
        d = (s - m_prev + M) % M;
        if (d == 1) begin
          m_dir = 0; wrapped = (m_prev == M - 1) && (s == 0);
        end else if (d == M - 1) begin
          m_dir = 1; wrapped = (m_prev == 0) && (s == M - 1);
        end else if (d != 0) m_flt = 1;
        if (!m_flt) m_prev = s;
      end
    end
    if (wrapped) begin
      m_wr   = 1;
      m_irq0 = (m_lap0 == IRQ_LAPS - 1) && (m_lap0 < 255);
      m_irq1 = (m_lap1 == IRQ_LAPS - 1) && (m_lap1 < 3);
      if (m_lap0 < 255) m_lap0++;
      if (m_lap1 < 3)   m_lap1++;
    end
  endfunction

  function automatic logic [17:0] expv();
    logic dv;
    logic [1:0] iq;
    dv = m_dir && !m_flt;
`ifdef COUNT_MON_IRQ_EN
    iq = {m_irq0, m_irq1};
`else
    iq = 2'b00;
`endif
    return {dv, m_flt, m_wr, 8'(m_lap0), dv, m_flt, m_wr, 2'(m_lap1), iq};
  endfunction

  task automatic tick(input bit c, input bit v, input int s);
    @(negedge clk);
    if0.clr = c; if0.cnt_vld = v; if0.cnt_in = 3'(s);
    if1.clr = c; if1.cnt_vld = v; if1.cnt_in = 3'(s);
    @(posedge clk);
    #1;
    model_step(c, v, s);
  endtask

  task automatic test_reset();
    if0.clr = 0; if0.cnt_vld = 0; if0.cnt_in = '0;
    if1.clr = 0; if1.cnt_vld = 0; if1.cnt_in = '0;
    model_clear();
    #1;
    n_cmp++;
    if (obs !== 18'd0) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", obs, 18'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    tick(0, 1, 5);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL reset_first_sample: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_up_wrap();
    int seq [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    tick(1, 0, 0);
    foreach (seq[i]) begin
      tick(0, 1, seq[i]);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL up_wrap[%0d]: got %b want %b", i, obs, expv());
      end
    end
    tick(0, 0, 0);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL up_wrap_after: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_down_wrap();
    int seq [4] = '{2, 1, 0, 7};
    tick(1, 0, 0);
    foreach (seq[i]) begin
      tick(0, 1, seq[i]);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL down_wrap[%0d]: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_fault();
    int seq [5] = '{3, 5, 6, 7, 0};
    tick(1, 0, 0);
    foreach (seq[i]) begin
      tick(0, 1, seq[i]);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL fault[%0d]: got %b want %b", i, obs, expv());
      end
    end
    tick(1, 0, 0);
    tick(0, 1, 4);
    tick(0, 1, 3);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL fault_clr: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_gaps();
    int seq [5] = '{4, 4, 4, 5, 4};
    tick(1, 0, 0);
    foreach (seq[i]) begin
      tick(0, 1, seq[i]);
      repeat (i % 3) tick(0, 0, $urandom_range(0, 7));
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL gaps[%0d]: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_clr_discard();
    tick(1, 0, 0);
    tick(0, 1, 7);
    tick(1, 1, 0);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL clr_discard: got %b want %b", obs, expv());
    end
    tick(0, 1, 3);
    tick(0, 1, 2);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL clr_first_sample: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_saturate();
    tick(1, 0, 0);
    for (int i = 0; i <= 5 * M; i++) begin
      tick(0, 1, i % M);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL saturate[%0d]: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 1, 7);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL async_setup: got %b want %b", obs, expv());
    end
    #2;
    reset = 1;
    #1;
    model_clear();
    n_cmp++;
    if (obs !== 18'd0) begin
      n_bad++; $display("FAIL async_reset_immediate: got %b want %b", obs, 18'd0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 18'd0) begin
      n_bad++; $display("FAIL async_reset_held: got %b want %b", obs, 18'd0);
    end
    @(negedge clk);
    reset = 0;
    tick(0, 1, 2);
    tick(0, 1, 5);
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL async_reset_resume: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_random();
    int r, delta, s;
    tick(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) tick(1, $urandom_range(0, 1), $urandom_range(0, 7));
      else if (r < 25) tick(0, 0, $urandom_range(0, 7));
      else begin
        r = $urandom_range(0, 99);
        if (r < 20)      delta = 0;
        else if (r < 58) delta = 1;
        else if (r < 96) delta = M - 1;
        else             delta = $urandom_range(0, 7);
        s = (m_prev + delta) % M;
        tick(0, 1, s);
      end
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL random[%0d]: got %b want %b", i, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_fault();
    test_gaps();
    test_clr_discard();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
